demux_burst_sched: RTL and testbench

- Streaming controller that sequences a 1-to-2 demultiplexer: accepts a valid/ready input stream and steers whole bursts to output 0 or output 1.
- Destination comes from a per-burst select bit or from round-robin alternation, and is locked for the full burst.
- Each output has a one-entry register stage with its own valid/ready handshake.
- Sits between a single producer and two consumers sharing that producer.

---
 rtl/demux_sched_pkg.sv | 17 +
 rtl/demux_out_slot.sv | 27 ++
 rtl/demux_burst_sched.sv | 142 ++++++++++++++
 tb/tb_demux_burst_sched.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/demux_sched_pkg.sv
// Shared definitions for the burst-steering demultiplexer: FSM encoding,
// mode values and default sizing.
package demux_sched_pkg;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_BURST = 1'b1
   } state_t;

   localparam logic MODE_SEL = 1'b0;
   localparam logic MODE_RR  = 1'b1;

   localparam int DEF_DW        = 8;
   localparam int DEF_BURST_MAX = 15;
   localparam int DEF_CW        = 8;

endpackage

// File: rtl/demux_out_slot.sv
// One-entry output register with a valid/ready handshake. A load and a drain
// in the same cycle keep valid high and take the new data.
module demux_out_slot #(
   parameter int DW = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          load,
   input  logic [DW-1:0] load_data,
   input  logic          ready,
   output logic          valid,
   output logic [DW-1:0] data
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid <= 1'b0;
         data  <= '0;
      end else if (load) begin
         valid <= 1'b1;
         data  <= load_data;
      end else if (valid && ready) begin
         valid <= 1'b0;
      end
   end

endmodule

// File: rtl/demux_burst_sched.sv
// Steers whole bursts from one valid/ready stream to one of two output slots.
// Optional per-destination burst counters: define DEMUX_BURST_SCHED_STATS_EN.
module demux_burst_sched
   import demux_sched_pkg::*;
#(
   parameter int DW        = DEF_DW,
   parameter int BURST_MAX = DEF_BURST_MAX,
   parameter int CW        = DEF_CW
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          mode,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [DW-1:0] in_data,
   input  logic          in_sel,
   input  logic          in_last,
   output logic          out0_valid,
   input  logic          out0_ready,
   output logic [DW-1:0] out0_data,
   output logic          out1_valid,
   input  logic          out1_ready,
   output logic [DW-1:0] out1_data,
   output logic          busy,
   output logic          cur_dest,
   output logic [CW-1:0] beat_cnt,
   output logic          overrun
`ifdef DEMUX_BURST_SCHED_STATS_EN
   ,
   output logic [15:0]   stat0_bursts,
   output logic [15:0]   stat1_bursts
`endif
);

   // Handshake: a beat transfers on any edge where valid && ready are both
   // high; valid never depends on ready, and in_ready only looks at the slot
   // the current burst is headed for.

   localparam logic [CW-1:0] CNT_MAX       = CW'(BURST_MAX);
   localparam bit            FORCE_ON_FIRST = (BURST_MAX == 1);

   state_t        state, state_nxt;
   logic          rr_ptr, rr_ptr_nxt;
   logic          lock_dest, lock_dest_nxt;
   logic          lock_mode, lock_mode_nxt;
   logic [CW-1:0] beat_cnt_nxt;
   logic          overrun_nxt;
   logic          dest;
   logic          accept;
   logic          eob;
   logic          burst_rr;
   logic [CW-1:0] cnt_inc;

   assign dest     = (state == ST_IDLE) ? ((mode == MODE_RR) ? rr_ptr : in_sel) : lock_dest;
   assign cur_dest = dest;
   assign in_ready = dest ? (!out1_valid || out1_ready) : (!out0_valid || out0_ready);
   assign accept   = in_valid && in_ready;
   assign busy     = (state == ST_BURST);
   assign cnt_inc  = beat_cnt + CW'(1);
   assign burst_rr = (state == ST_IDLE) ? (mode == MODE_RR) : (lock_mode == MODE_RR);

   always_comb begin
      state_nxt     = state;
      rr_ptr_nxt    = rr_ptr;
      lock_dest_nxt = lock_dest;
      lock_mode_nxt = lock_mode;
      beat_cnt_nxt  = beat_cnt;
      overrun_nxt   = overrun;
      eob           = 1'b0;
      if (accept) begin
         if (state == ST_IDLE) begin
            eob = in_last || FORCE_ON_FIRST;
            if (!eob) begin
               state_nxt     = ST_BURST;
               lock_dest_nxt = dest;
               lock_mode_nxt = mode;
               beat_cnt_nxt  = CW'(1);
            end
         end else begin
            eob          = in_last || (cnt_inc == CNT_MAX);
            beat_cnt_nxt = cnt_inc;
         end
         if (eob) begin
            state_nxt    = ST_IDLE;
            beat_cnt_nxt = '0;
            if (!in_last) overrun_nxt = 1'b1;
            if (burst_rr) rr_ptr_nxt = ~rr_ptr;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= ST_IDLE;
         rr_ptr    <= 1'b0;
         lock_dest <= 1'b0;
         lock_mode <= MODE_SEL;
         beat_cnt  <= '0;
         overrun   <= 1'b0;
      end else begin
         state     <= state_nxt;
         rr_ptr    <= rr_ptr_nxt;
         lock_dest <= lock_dest_nxt;
         lock_mode <= lock_mode_nxt;
         beat_cnt  <= beat_cnt_nxt;
         overrun   <= overrun_nxt;
      end
   end

   demux_out_slot #(.DW(DW)) u_slot0 (
      .clk       (clk),
      .rst       (rst),
      .load      (accept && !dest),
      .load_data (in_data),
      .ready     (out0_ready),
      .valid     (out0_valid),
      .data      (out0_data)
   );

   demux_out_slot #(.DW(DW)) u_slot1 (
      .clk       (clk),
      .rst       (rst),
      .load      (accept && dest),
      .load_data (in_data),
      .ready     (out1_ready),
      .valid     (out1_valid),
      .data      (out1_data)
   );

`ifdef DEMUX_BURST_SCHED_STATS_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stat0_bursts <= '0;
         stat1_bursts <= '0;
      end else if (eob) begin
         if (dest) stat1_bursts <= stat1_bursts + 16'd1;
         else      stat0_bursts <= stat0_bursts + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_demux_burst_sched.sv
// Directed bench for demux_burst_sched (BURST_MAX=4); covers reset, select and
// round-robin steering, backpressure, forced termination and optional stats.
module tb_demux_burst_sched;

   localparam int DW = 8;
   localparam int CW = 8;

   logic          clk = 1'b0;
   logic          rst;
   logic          mode;
   logic          in_valid;
   logic          in_ready;
   logic [DW-1:0] in_data;
   logic          in_sel;
   logic          in_last;
   logic          out0_valid;
   logic          out0_ready;
   logic [DW-1:0] out0_data;
   logic          out1_valid;
   logic          out1_ready;
   logic [DW-1:0] out1_data;
   logic          busy;
   logic          cur_dest;
   logic [CW-1:0] beat_cnt;
   logic          overrun;
`ifdef DEMUX_BURST_SCHED_STATS_EN
   logic [15:0]   stat0_bursts;
   logic [15:0]   stat1_bursts;
`endif

   int n_cmp = 0;
   int n_err = 0;

   demux_burst_sched #(.DW(DW), .BURST_MAX(4), .CW(CW)) dut (
      .clk        (clk),
      .rst        (rst),
      .mode       (mode),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_data    (in_data),
      .in_sel     (in_sel),
      .in_last    (in_last),
      .out0_valid (out0_valid),
      .out0_ready (out0_ready),
      .out0_data  (out0_data),
      .out1_valid (out1_valid),
      .out1_ready (out1_ready),
      .out1_data  (out1_data),
      .busy       (busy),
      .cur_dest   (cur_dest),
      .beat_cnt   (beat_cnt),
      .overrun    (overrun)
`ifdef DEMUX_BURST_SCHED_STATS_EN
      ,
      .stat0_bursts (stat0_bursts),
      .stat1_bursts (stat1_bursts)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [DW-1:0] d, input logic s, input logic l);
      in_valid = v;
      in_data  = d;
      in_sel   = s;
      in_last  = l;
      #1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; mode = 1'b0; in_valid = 1'b0; in_data = '0; in_sel = 1'b0; in_last = 1'b0;
      out0_ready = 1'b1; out1_ready = 1'b1;
      #1;
      chk("rst_out0_valid", 32'(out0_valid), 0);
      chk("rst_out1_valid", 32'(out1_valid), 0);
      chk("rst_in_ready",   32'(in_ready), 1);
      chk("rst_beat_cnt",   32'(beat_cnt), 0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      #1;

      // select mode, 3-beat burst to out1; in_sel ignored after first beat
      drive(1, 'hA1, 1, 0);
      chk("sel_dest0", 32'(cur_dest), 1);
      chk("sel_busy0", 32'(busy), 0);
      tick();
      chk("sel_v1", 32'(out1_valid), 1);
      chk("sel_d1", 32'(out1_data), 'hA1);
      chk("sel_cnt1", 32'(beat_cnt), 1);
      drive(1, 'hB2, 0, 0);
      chk("sel_dest1", 32'(cur_dest), 1);
      chk("sel_busy1", 32'(busy), 1);
      tick();
      chk("sel_d2", 32'(out1_data), 'hB2);
      chk("sel_cnt2", 32'(beat_cnt), 2);
      chk("sel_o0v", 32'(out0_valid), 0);
      drive(1, 'hC3, 0, 1);
      chk("sel_busy2", 32'(busy), 1);
      tick();
      chk("sel_d3", 32'(out1_data), 'hC3);
      chk("sel_busy_end", 32'(busy), 0);
      chk("sel_cnt_end", 32'(beat_cnt), 0);
      drive(0, 'h00, 0, 0);
      tick();
      chk("sel_drain", 32'(out1_valid), 0);
      chk("sel_o0v_end", 32'(out0_valid), 0);

      // round-robin: four single-beat bursts alternate 0,1,0,1
      mode = 1'b1;
      drive(1, 'hD0, 1, 1);
      chk("rr_dest0", 32'(cur_dest), 0);
      tick();
      chk("rr_d0", 32'(out0_data), 'hD0);
      drive(1, 'hD1, 0, 1);
      chk("rr_dest1", 32'(cur_dest), 1);
      tick();
      chk("rr_d1", 32'(out1_data), 'hD1);
      drive(1, 'hD2, 1, 1);
      chk("rr_dest2", 32'(cur_dest), 0);
      tick();
      chk("rr_d2", 32'(out0_data), 'hD2);
      drive(1, 'hD3, 0, 1);
      chk("rr_dest3", 32'(cur_dest), 1);
      tick();
      chk("rr_d3", 32'(out1_data), 'hD3);
      drive(0, 'h00, 1, 0);
      chk("rr_ptr_wrap", 32'(cur_dest), 0);
      mode = 1'b0;
      tick();

      // backpressure on out0
      out0_ready = 1'b0;
      drive(1, 'hE0, 0, 0);
      chk("bp_rdy0", 32'(in_ready), 1);
      tick();
      chk("bp_d0", 32'(out0_data), 'hE0);
      drive(1, 'hE1, 1, 0);
      chk("bp_stall", 32'(in_ready), 0);
      chk("bp_dest", 32'(cur_dest), 0);
      tick();
      tick();
      chk("bp_hold", 32'(out0_data), 'hE0);
      chk("bp_cnt_hold", 32'(beat_cnt), 1);
      out0_ready = 1'b1;
      #1;
      chk("bp_resume", 32'(in_ready), 1);
      tick();
      chk("bp_d1", 32'(out0_data), 'hE1);
      chk("bp_cnt2", 32'(beat_cnt), 2);
      drive(1, 'hE2, 1, 1);
      tick();
      chk("bp_d2", 32'(out0_data), 'hE2);
      chk("bp_busy_end", 32'(busy), 0);
      drive(0, 'h00, 0, 0);
      tick();
      chk("bp_drain", 32'(out0_valid), 0);
      chk("bp_o1v", 32'(out1_valid), 0);

      // forced termination at BURST_MAX=4
      chk("ov_pre", 32'(overrun), 0);
      drive(1, 'hF0, 1, 0); tick();
      drive(1, 'hF1, 1, 0); tick();
      drive(1, 'hF2, 1, 0); tick();
      chk("ov_cnt3", 32'(beat_cnt), 3);
      chk("ov_d2", 32'(out1_data), 'hF2);
      drive(1, 'hF3, 1, 0); tick();
      chk("ov_d3", 32'(out1_data), 'hF3);
      chk("ov_flag", 32'(overrun), 1);
      chk("ov_busy", 32'(busy), 0);
      chk("ov_cnt0", 32'(beat_cnt), 0);
      drive(1, 'hF4, 0, 0);
      chk("ov_resample", 32'(cur_dest), 0);
      tick();
      chk("ov_d4", 32'(out0_data), 'hF4);
      chk("ov_busy2", 32'(busy), 1);
      drive(1, 'hF5, 1, 1);
      chk("ov_lock2", 32'(cur_dest), 0);
      tick();
      chk("ov_d5", 32'(out0_data), 'hF5);
      chk("ov_sticky", 32'(overrun), 1);
      chk("ov_o1_keep", 32'(out1_data), 'hF3);

      // asynchronous reset mid-burst
      drive(1, 'h5A, 1, 0);
      tick();
      chk("mr_pre_busy", 32'(busy), 1);
      rst = 1'b1;
      #1;
      chk("mr_o0v", 32'(out0_valid), 0);
      chk("mr_o1v", 32'(out1_valid), 0);
      chk("mr_o0d", 32'(out0_data), 0);
      chk("mr_o1d", 32'(out1_data), 0);
      chk("mr_busy", 32'(busy), 0);
      chk("mr_cnt", 32'(beat_cnt), 0);
      chk("mr_ovr", 32'(overrun), 0);
      chk("mr_rdy", 32'(in_ready), 1);
`ifdef DEMUX_BURST_SCHED_STATS_EN
      chk("mr_stat0", 32'(stat0_bursts), 0);
      chk("mr_stat1", 32'(stat1_bursts), 0);
`endif
      drive(0, 'h00, 0, 0);
      tick();
      rst = 1'b0;
      tick();
      chk("mr_no_resume", 32'(busy), 0);

      // two bursts to out0, three to out1
      drive(1, 'h60, 0, 1); tick();
      chk("st_d0", 32'(out0_data), 'h60);
      drive(1, 'h61, 0, 1); tick();
      chk("st_d1", 32'(out0_data), 'h61);
      drive(1, 'h62, 1, 1); tick();
      drive(1, 'h63, 1, 1); tick();
      drive(1, 'h64, 1, 1); tick();
      chk("st_d4", 32'(out1_data), 'h64);
      drive(0, 'h00, 0, 0);
`ifdef DEMUX_BURST_SCHED_STATS_EN
      chk("st_stat0", 32'(stat0_bursts), 2);
      chk("st_stat1", 32'(stat1_bursts), 3);
      rst = 1'b1;
      #1;
      chk("st_rst0", 32'(stat0_bursts), 0);
      chk("st_rst1", 32'(stat1_bursts), 0);
      rst = 1'b0;
`endif
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
